// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with registered top-of-stack, status decodes,
// sticky overflow/underflow flags, push+pop replace-top and synchronous flush.
module param_stack #(
   parameter int DATA_W = 18,
   parameter int DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic                          flush,
   input  logic                          clr_err,
   input  logic [DATA_W-1:0]             din,
   output logic [DATA_W-1:0]             dout,
   output logic                          empty,
   output logic                          full,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow,
   output logic                          underflow
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W:0]    r_count;
   logic [DATA_W-1:0] r_dout;
   logic              r_ovf;
   logic              r_unf;

   logic              w_empty;
   logic              w_full;
   logic              w_rep;
   logic              w_psh;
   logic              w_pop;
   logic              w_we;
   logic              w_ovf_ev;
   logic              w_unf_ev;
   logic [PTR_W-1:0]  w_wr_idx;
   logic [PTR_W-1:0]  w_below_idx;
   logic [PTR_W:0]    w_count_nx;
   logic [DATA_W-1:0] w_dout_nx;

   always_comb begin
      w_empty     = r_count == '0;
      w_full      = r_count == (PTR_W+1)'(DEPTH);
      w_rep       = push && pop && !w_empty;
      w_psh       = push && !w_rep && !w_full;
      w_pop       = pop && !push && !w_empty;
      w_we        = !flush && (w_psh || w_rep);
      w_ovf_ev    = !flush && push && !pop && w_full;
      w_unf_ev    = !flush && pop && !push && w_empty;
      // Low PTR_W bits suffice: the full case wraps to the right slot modulo DEPTH
      w_wr_idx    = w_rep ? r_count[PTR_W-1:0] - PTR_W'(1) : r_count[PTR_W-1:0];
      w_below_idx = r_count[PTR_W-1:0] - PTR_W'(2);
      w_count_nx  = flush ? '0 : w_psh ? r_count + 1'b1 : w_pop ? r_count - 1'b1 : r_count;
      w_dout_nx   = flush ? '0 :
                    (w_psh || w_rep) ? din :
                    w_pop ? (r_count > (PTR_W+1)'(1) ? r_mem[w_below_idx] : '0) :
                    r_dout;
   end

   always_ff @(posedge clk) begin
      if (rst && w_we) r_mem[w_wr_idx] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_dout  <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_count_nx;
         r_dout  <= w_dout_nx;
         r_ovf   <= w_ovf_ev || (r_ovf && !clr_err);
         r_unf   <= w_unf_ev || (r_unf && !clr_err);
      end
   end

   assign dout      = r_dout;
   assign count     = r_count;
   assign empty     = w_empty;
   assign full      = w_full;
   assign overflow  = r_ovf;
   assign underflow = r_unf;
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: directed checks of param_stack with DEPTH=4, DATA_W=18.
module tb_param_stack;
   localparam int DATA_W = 18;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic              flush = 1'b0;
   logic              clr_err = 1'b0;
   logic [DATA_W-1:0] din = '0;
   logic [DATA_W-1:0] dout;
   logic              empty;
   logic              full;
   logic [2:0]        count;
   logic              overflow;
   logic              underflow;

   int checks = 0;
   int errors = 0;

   param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
      .clr_err(clr_err), .din(din), .dout(dout), .empty(empty), .full(full),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic pu, input logic po, input logic fl, input logic ce,
                       input logic [DATA_W-1:0] d);
      @(negedge clk);
      push = pu; pop = po; flush = fl; clr_err = ce; din = d;
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
   endtask

   task automatic status(input string tag, input logic [31:0] c, input logic [31:0] d,
                         input logic e, input logic f, input logic ov, input logic un);
      chk({tag, "_count"}, 32'(count), c);
      chk({tag, "_dout"}, 32'(dout), d);
      chk({tag, "_empty"}, 32'(empty), 32'(e));
      chk({tag, "_full"}, 32'(full), 32'(f));
      chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
      chk({tag, "_unf"}, 32'(underflow), 32'(un));
   endtask

   initial begin
      #12;
      status("reset", 0, 0, 1, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      step(1, 0, 0, 0, 18'h00011);
      step(1, 0, 0, 0, 18'h00022);
      step(1, 0, 0, 0, 18'h00033);
      status("pre_rst", 3, 18'h00033, 0, 0, 0, 0);
      // asynchronous reset while a push is pending
      @(negedge clk);
      push = 1'b1; din = 18'h00044;
      #2 rst = 1'b0;
      #1;
      status("mid_rst", 0, 0, 1, 0, 0, 0);
      push = 1'b0; din = '0;
      @(negedge clk);
      rst = 1'b1;
      step(0, 1, 0, 0, '0);
      status("unf", 0, 0, 1, 0, 0, 1);
      step(0, 0, 0, 1, '0);
      status("clr_unf", 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 18'h00011);
      step(1, 0, 0, 0, 18'h00022);
      step(1, 0, 0, 0, 18'h00033);
      step(1, 0, 0, 0, 18'h00044);
      status("full", 4, 18'h00044, 0, 1, 0, 0);
      step(1, 0, 0, 0, 18'h00055);
      status("ovf", 4, 18'h00044, 0, 1, 1, 0);
      step(1, 0, 0, 1, 18'h00066);
      status("clr_vs_ovf", 4, 18'h00044, 0, 1, 1, 0);
      step(0, 0, 0, 1, '0);
      status("clr_ovf", 4, 18'h00044, 0, 1, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop1", 3, 18'h00033, 0, 0, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop2", 2, 18'h00022, 0, 0, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop3", 1, 18'h00011, 0, 0, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop4", 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 18'h00011);
      step(1, 0, 0, 0, 18'h00022);
      step(1, 0, 0, 0, 18'h00033);
      step(1, 0, 0, 0, 18'h00044);
      step(1, 1, 0, 0, 18'h3ABCD);
      status("rep_full", 4, 18'h3ABCD, 0, 1, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop_after_rep", 3, 18'h00033, 0, 0, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop_to2", 2, 18'h00022, 0, 0, 0, 0);
      step(1, 1, 0, 0, 18'h3FFFF);
      status("rep2", 2, 18'h3FFFF, 0, 0, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop_rep2", 1, 18'h00011, 0, 0, 0, 0);
      step(0, 1, 0, 0, '0);
      status("pop_empty", 0, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 18'h12345);
      status("rep_empty", 1, 18'h12345, 0, 0, 0, 0);
      step(1, 0, 0, 0, 18'h00022);
      step(1, 0, 0, 0, 18'h00033);
      status("pre_flush", 3, 18'h00033, 0, 0, 0, 0);
      step(1, 0, 1, 0, 18'h00077);
      status("flush", 0, 0, 1, 0, 0, 0);
      step(0, 1, 1, 0, '0);
      status("flush_pop", 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 18'h00066);
      status("post_flush", 1, 18'h00066, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
